// File: rtl/dlx_sdram_ctrl.sv
// dlx_sdram_ctrl: UDLX data port to SDRAM command controller (init, auto-refresh, single-word access).
// Optional SDRAM_AUTO_PRECHARGE_EN: RD/WR carry auto-precharge (addr[10]=1) instead of an explicit PRE.
module dlx_sdram_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 20,
    parameter int DRAM_ADDR_WIDTH = 12,
    parameter int INIT_CYCLES     = 100,
    parameter int REFRESH_CYCLES  = 780,
    parameter int CAS_LATENCY     = 2,
    parameter int TRCD            = 2,
    parameter int TRP             = 2,
    parameter int TRFC            = 7,
    parameter int TWR             = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic [DATA_WIDTH-1:0]      data_read,
    output logic                       data_ack,
    output logic                       init_done,
    output logic                       dram_cke,
    output logic                       dram_cs_n,
    output logic                       dram_ras_n,
    output logic                       dram_cas_n,
    output logic                       dram_we_n,
    output logic [1:0]                 dram_ba,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0]      dram_dq_out,
    output logic                       dram_dq_oe,
    input  logic [DATA_WIDTH-1:0]      dram_dq_in
);
    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RW,
        CAS_WAIT, WR_REC, PRE, REF, DONE
    } state_t;

`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam logic AP = 1'b1;
`else
    localparam logic AP = 1'b0;
`endif

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam int CW  = $clog2(INIT_CYCLES + TRFC + TWR + TRP + CAS_LATENCY + TRCD + 2);
    localparam int RCW = $clog2(REFRESH_CYCLES + 1);

    // Wait loads hold "cycles until next command minus one"; the state moves on when cnt_q hits 0.
    localparam logic [CW-1:0]  C_INIT    = CW'(INIT_CYCLES);
    localparam logic [CW-1:0]  C_TRP     = CW'(TRP - 1);
    localparam logic [CW-1:0]  C_TRFC    = CW'(TRFC - 1);
    localparam logic [CW-1:0]  C_TRCD    = CW'(TRCD - 1);
    localparam logic [CW-1:0]  C_TWR     = CW'(TWR - 1);
    localparam logic [CW-1:0]  C_TWR_TRP = CW'(TWR + TRP - 1);
    localparam logic [CW-1:0]  C_CL      = CW'(CAS_LATENCY - 1);
    localparam logic [CW-1:0]  C_MRS     = CW'(1);
    localparam logic [RCW-1:0] C_REF     = RCW'(REFRESH_CYCLES);

    localparam logic [DRAM_ADDR_WIDTH-1:0] A_PALL = DRAM_ADDR_WIDTH'(11'h400);
    localparam logic [DRAM_ADDR_WIDTH-1:0] A_MODE = DRAM_ADDR_WIDTH'({3'(CAS_LATENCY), 4'b0000});

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [3:0]                 cmd_q, cmd_d;
    logic                       cke_q;
    logic [1:0]                 ba_q, ba_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      dq_out_q, dq_out_d;
    logic                       dq_oe_q, dq_oe_d;
    logic [DATA_WIDTH-1:0]      data_read_q, data_read_d;
    logic                       ack_q, ack_d;
    logic                       init_done_q, init_done_d;
    logic [RCW-1:0]             ref_cnt_q, ref_cnt_d;
    logic                       ref_pend_q, ref_pend_d;
    logic                       expire;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - 1'b1;
        cmd_d       = CMD_NOP;
        ba_d        = ba_q;
        addr_d      = addr_q;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        data_read_d = data_read_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        expire      = init_done_q && ref_cnt_q == RCW'(1);
        ref_cnt_d   = (!init_done_q || expire) ? C_REF : ref_cnt_q - 1'b1;
        ref_pend_d  = ref_pend_q || expire;
        case (state_q)
            INIT_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_INIT) begin
                    state_d = INIT_PRE;
                    cmd_d   = CMD_PRE;
                    addr_d  = A_PALL;
                    ba_d    = '0;
                    cnt_d   = C_TRP;
                end
            end
            INIT_PRE: if (cnt_q == '0) begin
                state_d = INIT_REF1;
                cmd_d   = CMD_REF;
                cnt_d   = C_TRFC;
            end
            INIT_REF1: if (cnt_q == '0) begin
                state_d = INIT_REF2;
                cmd_d   = CMD_REF;
                cnt_d   = C_TRFC;
            end
            INIT_REF2: if (cnt_q == '0) begin
                state_d = INIT_MRS;
                cmd_d   = CMD_MRS;
                addr_d  = A_MODE;
                ba_d    = '0;
                cnt_d   = C_MRS;
            end
            INIT_MRS: if (cnt_q == '0) begin
                state_d     = IDLE;
                init_done_d = 1'b1;
            end
            IDLE: begin
                // A refresh expiring this very cycle already beats a waiting request.
                if (ref_pend_q || expire) begin
                    state_d    = REF;
                    cmd_d      = CMD_REF;
                    cnt_d      = C_TRFC;
                    ref_pend_d = 1'b0;
                end else if (data_wr_en || data_rd_en) begin
                    if (data_addr[19]) begin
                        state_d     = DONE;
                        ack_d       = 1'b1;
                        data_read_d = '0;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            ACT: begin
                state_d = RW;
                cmd_d   = CMD_ACT;
                addr_d  = DRAM_ADDR_WIDTH'(data_addr[18:10]);
                ba_d    = data_addr[9:8];
                cnt_d   = C_TRCD;
            end
            RW: if (cnt_q == '0) begin
                addr_d = DRAM_ADDR_WIDTH'({AP, 2'b00, data_addr[7:0]});
                ba_d   = data_addr[9:8];
                if (data_wr_en) begin
                    state_d  = WR_REC;
                    cmd_d    = CMD_WR;
                    dq_oe_d  = 1'b1;
                    dq_out_d = data_write;
                    ack_d    = 1'b1;
                    cnt_d    = AP ? C_TWR_TRP : C_TWR;
                end else begin
                    state_d = CAS_WAIT;
                    cmd_d   = CMD_RD;
                    cnt_d   = C_CL;
                end
            end
            CAS_WAIT: if (cnt_q == '0) begin
                state_d     = WR_REC;
                data_read_d = dram_dq_in;
                ack_d       = 1'b1;
                cnt_d       = AP ? C_TRP : '0;
            end
            // Shared recovery wait: ends in PRE, or straight in IDLE when the bank self-precharges.
            WR_REC: if (cnt_q == '0) begin
                if (AP) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRE;
                    cmd_d   = CMD_PRE;
                    cnt_d   = C_TRP;
                end
            end
            PRE: if (cnt_q == '0) state_d = IDLE;
            REF: if (cnt_q == '0) state_d = IDLE;
            DONE: state_d = IDLE;
            default: state_d = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_WAIT;
            cnt_q       <= '0;
            cmd_q       <= 4'b1111;
            cke_q       <= 1'b0;
            ba_q        <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            data_read_q <= '0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            ref_cnt_q   <= C_REF;
            ref_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cke_q       <= 1'b1;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            data_read_q <= data_read_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
        end
    end

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
    assign dram_cke    = cke_q;
    assign dram_ba     = ba_q;
    assign dram_addr   = addr_q;
    assign dram_dq_out = dq_out_q;
    assign dram_dq_oe  = dq_oe_q;
    assign data_read   = data_read_q;
    assign data_ack    = ack_q;
    assign init_done   = init_done_q;
endmodule

// File: tb/tb_dlx_sdram_ctrl.sv
// tb_dlx_sdram_ctrl: directed checks of init, access, priority, refresh and non-SDRAM paths.
// dut uses the default refresh period, dut_r a 20-cycle period for refresh interaction.
module tb_dlx_sdram_ctrl;
`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam logic AP = 1'b1;
`else
    localparam logic AP = 1'b0;
`endif
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rd_en = 0, wr_en = 0, rd_en_r = 0, wr_en_r = 0;
    logic [19:0] addr = '0, addr_r = '0;
    logic [31:0] wdata = '0, wdata_r = '0, dq_in = '0, dq_in_r = '0;
    logic [31:0] rdata, rdata_r, dq_out, dq_out_r;
    logic        ack, ack_r, idone, idone_r, cke, cke_r, cs_n, ras_n, cas_n, we_n;
    logic        cs_n_r, ras_n_r, cas_n_r, we_n_r, dq_oe, dq_oe_r;
    logic [1:0]  ba, ba_r;
    logic [11:0] daddr, daddr_r;
    logic [3:0]  cmd, cmd_r;
    int          cyc = 0, total = 0, bad = 0;

    assign cmd   = {cs_n, ras_n, cas_n, we_n};
    assign cmd_r = {cs_n_r, ras_n_r, cas_n_r, we_n_r};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    dlx_sdram_ctrl #(.INIT_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .data_rd_en(rd_en), .data_wr_en(wr_en), .data_addr(addr),
        .data_write(wdata), .data_read(rdata), .data_ack(ack), .init_done(idone),
        .dram_cke(cke), .dram_cs_n(cs_n), .dram_ras_n(ras_n), .dram_cas_n(cas_n),
        .dram_we_n(we_n), .dram_ba(ba), .dram_addr(daddr), .dram_dq_out(dq_out),
        .dram_dq_oe(dq_oe), .dram_dq_in(dq_in)
    );

    dlx_sdram_ctrl #(.INIT_CYCLES(10), .REFRESH_CYCLES(20)) dut_r (
        .clk(clk), .rst_n(rst_n), .data_rd_en(rd_en_r), .data_wr_en(wr_en_r), .data_addr(addr_r),
        .data_write(wdata_r), .data_read(rdata_r), .data_ack(ack_r), .init_done(idone_r),
        .dram_cke(cke_r), .dram_cs_n(cs_n_r), .dram_ras_n(ras_n_r), .dram_cas_n(cas_n_r),
        .dram_we_n(we_n_r), .dram_ba(ba_r), .dram_addr(daddr_r), .dram_dq_out(dq_out_r),
        .dram_dq_oe(dq_oe_r), .dram_dq_in(dq_in_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if (cke !== 1'b0) begin bad++; $display("FAIL rst_cke got=%b want=0", cke); end
        total++; if (cmd !== 4'b1111) begin bad++; $display("FAIL rst_cmd got=%b want=1111", cmd); end
        total++; if ({ba, daddr} !== 14'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", {ba, daddr}); end
        total++; if ({dq_oe, dq_out} !== 33'h0) begin bad++; $display("FAIL rst_dq got=%h want=0", {dq_oe, dq_out}); end
        total++; if ({rdata, ack, idone} !== 34'h0) begin bad++; $display("FAIL rst_cpu got=%h want=0", {rdata, ack, idone}); end
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        int stray = 0, acks = 0;
        wr_en = 1'b1;
        addr  = 20'h80000;
        tick();
        total++; if (cke !== 1'b1) begin bad++; $display("FAIL init_cke got=%b want=1", cke); end
        while (cyc < 29) begin
            tick();
            if (ack) acks++;
            if (!(cyc inside {11, 13, 20, 27}) && cmd !== NOP) stray++;
            if (cyc == 11) begin
                total++; if (cmd !== PRE || daddr[10] !== 1'b1) begin bad++; $display("FAIL init_pre got=%b/%b want=0010/1", cmd, daddr[10]); end
            end
            if (cyc == 13 || cyc == 20) begin
                total++; if (cmd !== REF) begin bad++; $display("FAIL init_ref@%0d got=%b want=0001", cyc, cmd); end
            end
            if (cyc == 27) begin
                total++; if (cmd !== MRS || daddr !== 12'h020) begin bad++; $display("FAIL init_mrs got=%b/%h want=0000/020", cmd, daddr); end
            end
            if (cyc == 28) begin
                total++; if (idone !== 1'b0) begin bad++; $display("FAIL init_done_early got=%b want=0", idone); end
            end
        end
        total++; if (idone !== 1'b1) begin bad++; $display("FAIL init_done got=%b want=1", idone); end
        total++; if (stray !== 0) begin bad++; $display("FAIL init_stray got=%0d want=0", stray); end
        total++; if (acks !== 0) begin bad++; $display("FAIL init_holdoff got=%0d want=0", acks); end
        tick();
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL init_first_ack got=%b want=1", ack); end
        wr_en = 1'b0;
        tick();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL init_ack_pulse got=%b want=0", ack); end
    endtask

    task automatic test_refresh();
        int early = 0, refs = 0;
        wait_until(48);
        wr_en_r = 1'b1; addr_r = 20'h00412; wdata_r = 32'h12345678;
        while (cyc < 64) begin
            tick();
            if (cyc > 49 && cyc < 58 && cmd_r === ACT) early++;
            if (cyc == 49) begin
                total++; if (cmd_r !== REF) begin bad++; $display("FAIL ref_first got=%b want=0001", cmd_r); end
            end
            if (cyc == 58) begin
                total++; if (cmd_r !== ACT || daddr_r !== 12'h001 || ba_r !== 2'd0) begin bad++; $display("FAIL ref_act got=%b/%h/%0d want=0011/001/0", cmd_r, daddr_r, ba_r); end
            end
            if (cyc == 60) begin
                total++; if (cmd_r !== WR || daddr_r !== {1'b0, AP, 2'b00, 8'h12} || ack_r !== 1'b1 || dq_out_r !== 32'h12345678) begin bad++; $display("FAIL ref_wr got=%b/%h/%b/%h", cmd_r, daddr_r, ack_r, dq_out_r); end
                wr_en_r = 1'b0;
            end
        end
        total++; if (early !== 0) begin bad++; $display("FAIL ref_act_early got=%0d want=0", early); end
        wait_until(69);
        total++; if (cmd_r !== REF) begin bad++; $display("FAIL ref_period got=%b want=0001", cmd_r); end
        wait_until(84);
        wr_en_r = 1'b1; addr_r = 20'h00C01; wdata_r = 32'h0F0F0F0F;
        while (cyc < 93) begin
            tick();
            if (cyc < 93 && cmd_r === REF) refs++;
            if (cyc == 88) begin
                total++; if (cmd_r !== WR || ack_r !== 1'b1) begin bad++; $display("FAIL ref_inflight_wr got=%b/%b want=0100/1", cmd_r, ack_r); end
                wr_en_r = 1'b0;
            end
        end
        total++; if (refs !== 0) begin bad++; $display("FAIL ref_preempt got=%0d want=0", refs); end
        total++; if (cmd_r !== REF) begin bad++; $display("FAIL ref_sticky got=%b want=0001", cmd_r); end
    endtask

    task automatic test_write();
        int s = cyc + 1;
        wr_en = 1'b1; addr = 20'h00305; wdata = 32'hDEADBEEF;
        while (cyc < s + 8) begin
            tick();
            if (cyc == s + 1) begin
                total++; if (cmd !== ACT || daddr !== 12'h000 || ba !== 2'd3) begin bad++; $display("FAIL wr_act got=%b/%h/%0d want=0011/000/3", cmd, daddr, ba); end
            end
            if (cyc == s + 2) begin
                total++; if (cmd !== NOP || ack !== 1'b0) begin bad++; $display("FAIL wr_trcd got=%b/%b want=0111/0", cmd, ack); end
            end
            if (cyc == s + 3) begin
                total++; if (cmd !== WR || daddr !== {1'b0, AP, 2'b00, 8'h05} || ba !== 2'd3) begin bad++; $display("FAIL wr_cmd got=%b/%h/%0d", cmd, daddr, ba); end
                total++; if (dq_oe !== 1'b1 || dq_out !== 32'hDEADBEEF || ack !== 1'b1) begin bad++; $display("FAIL wr_data got=%b/%h/%b want=1/deadbeef/1", dq_oe, dq_out, ack); end
                wr_en = 1'b0;
            end
            if (cyc == s + 4) begin
                total++; if (dq_oe !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL wr_after got=%b/%b want=0/0", dq_oe, ack); end
            end
            if (cyc == s + 5) begin
                total++; if (cmd !== (AP ? NOP : PRE) || ba !== 2'd3 || daddr[10] !== AP) begin bad++; $display("FAIL wr_pre got=%b/%0d/%b", cmd, ba, daddr[10]); end
            end
        end
    endtask

    task automatic test_read();
        int s = cyc + 1;
        rd_en = 1'b1; addr = 20'h00305; dq_in = 32'hA5A5A5A5;
        while (cyc < s + 9) begin
            tick();
            if (cyc == s + 1) begin
                total++; if (cmd !== ACT || ba !== 2'd3) begin bad++; $display("FAIL rd_act got=%b/%0d want=0011/3", cmd, ba); end
            end
            if (cyc == s + 3) begin
                total++; if (cmd !== RD || daddr !== {1'b0, AP, 2'b00, 8'h05} || ba !== 2'd3) begin bad++; $display("FAIL rd_cmd got=%b/%h/%0d", cmd, daddr, ba); end
            end
            if (cyc == s + 4) begin
                total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_ack_early got=%b want=0", ack); end
                dq_in = 32'hDEADBEEF;
            end
            if (cyc == s + 5) begin
                total++; if (ack !== 1'b1 || rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%b/%h want=1/deadbeef", ack, rdata); end
                dq_in = 32'hA5A5A5A5;
                rd_en = 1'b0;
            end
            if (cyc == s + 6) begin
                total++; if (ack !== 1'b0 || rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%b/%h want=0/deadbeef", ack, rdata); end
                total++; if (cmd !== (AP ? NOP : PRE)) begin bad++; $display("FAIL rd_pre got=%b", cmd); end
            end
        end
    endtask

    task automatic test_both();
        int rds = 0;
        int s = cyc + 1;
        rd_en = 1'b1; wr_en = 1'b1; addr = 20'h00010; wdata = 32'hCAFEF00D;
        while (cyc < s + 8) begin
            tick();
            if (cmd === RD) rds++;
            if (cyc == s + 3) begin
                total++; if (cmd !== WR || ack !== 1'b1 || dq_out !== 32'hCAFEF00D) begin bad++; $display("FAIL both_wr got=%b/%b/%h", cmd, ack, dq_out); end
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        total++; if (rds !== 0) begin bad++; $display("FAIL both_no_rd got=%0d want=0", rds); end
        s = cyc + 1;
        rd_en = 1'b1;
        while (cyc < s + 9) begin
            tick();
            if (cyc == s + 3) begin
                total++; if (cmd !== RD || daddr[7:0] !== 8'h10) begin bad++; $display("FAIL both_rd got=%b/%h want=0101/10", cmd, daddr[7:0]); end
            end
            if (cyc == s + 4) dq_in = 32'h0BADF00D;
            if (cyc == s + 5) begin
                total++; if (ack !== 1'b1 || rdata !== 32'h0BADF00D) begin bad++; $display("FAIL both_rd_data got=%b/%h want=1/0badf00d", ack, rdata); end
                rd_en = 1'b0; dq_in = 32'hA5A5A5A5;
            end
        end
    endtask

    task automatic test_nonsdram();
        int s = cyc + 1;
        int cmds = 0;
        wr_en = 1'b1; addr = 20'h80000; wdata = 32'h11111111;
        tick();
        total++; if (ack !== 1'b1 || cmd !== NOP) begin bad++; $display("FAIL ns_wr_ack got=%b/%b want=1/0111", ack, cmd); end
        wr_en = 1'b0;
        tick();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL ns_wr_pulse got=%b want=0", ack); end
        tick();
        rd_en = 1'b1; addr = 20'h80123;
        while (cyc < s + 5) begin
            tick();
            if (cmd !== NOP) cmds++;
            if (cyc == s + 3) begin
                total++; if (ack !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL ns_rd got=%b/%h want=1/0", ack, rdata); end
                rd_en = 1'b0;
            end
        end
        total++; if (cmds !== 0) begin bad++; $display("FAIL ns_pins got=%0d want=0", cmds); end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int s = cyc + 1;
        rd_en = 1'b1; addr = 20'h00305;
        wait_until(s + 2);
        rst_n = 1'b0;
        #1;
        total++; if (cke !== 1'b0 || cmd !== 4'b1111 || ack !== 1'b0 || idone !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL mid_rst got=%b/%b/%b/%b/%h", cke, cmd, ack, idone, rdata); end
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        while (cyc < 30) begin
            tick();
            if (ack) acks++;
            if (cyc == 11) begin
                total++; if (cmd !== PRE) begin bad++; $display("FAIL mid_pre got=%b want=0010", cmd); end
            end
        end
        total++; if (acks !== 0 || idone !== 1'b1) begin bad++; $display("FAIL mid_restart got=%0d/%b want=0/1", acks, idone); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_refresh();
        test_write();
        test_read();
        test_both();
        test_nonsdram();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
